// File: rtl/ccu_cmd_parser.sv
// ccu_cmd_parser
// Frame parser between the SPI receive stage and the CCU.
// Frame format: SYNC, CMD, LEN, PAYLOAD[LEN], CHK, with CHK = XOR of CMD, LEN and payload.
// A validated frame is held for the CCU behind a valid/ready handshake. The payload
// is read through a combinational random-access port.
// Optional feature: define CCU_CMD_TIMEOUT_EN to add an inter-byte timeout and the
// err_timeout output.
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | dropping bytes until SYNC_BYTE is seen
// CMD   | next byte is the opcode
// LEN   | next byte is the payload length
// PAY   | collecting payload bytes into the buffer
// CHK   | next byte is the checksum
// HOLD  | validated command presented to the CCU; upstream stalled

module ccu_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         AW             = $clog2(MAX_LEN),
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic [7:0]    s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_opcode,
    output logic [7:0]    cmd_len,
    input  logic [AW-1:0] cmd_rd_addr,
    output logic [7:0]    cmd_rd_data,
    output logic          err_chk,
    output logic          err_len,
    output logic [7:0]    err_cnt
`ifdef CCU_CMD_TIMEOUT_EN
    ,
    output logic          err_timeout
`endif
);

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        CMD  = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CHK  = 3'd4,
        HOLD = 3'd5
    } state_t;

    state_t        state;
    logic [7:0]    checksum;
    logic [AW-1:0] wr_idx;
    logic [7:0]    buffer [MAX_LEN];
    logic          accept;
    logic          timeout_hit;
    logic [31:0]   rd_addr_ext;

    // tlast marks FIFO-drain boundaries upstream and carries no framing meaning.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign rd_addr_ext = 32'(cmd_rd_addr);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef CCU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          in_frame;

    assign in_frame    = (state == CMD) || (state == LEN) || (state == PAY) || (state == CHK);
    assign timeout_hit = in_frame && !accept && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter; restarts on every accepted byte and on a timeout.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            to_cnt <= '0;
        end else if (accept || !in_frame || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Framing FSM with registered handshake, header fields and error pulses.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state         <= HUNT;
            s_axis_tready <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_opcode    <= 8'h00;
            cmd_len       <= 8'h00;
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            err_cnt       <= 8'h00;
            checksum      <= 8'h00;
            wr_idx        <= '0;
`ifdef CCU_CMD_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
        end else begin
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            s_axis_tready <= 1'b1;
`ifdef CCU_CMD_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
            case (state)
                HUNT: begin
                    if (accept && s_axis_tdata == SYNC_BYTE) begin
                        state    <= CMD;
                        checksum <= 8'h00;
                        wr_idx   <= '0;
                    end
                end
                CMD: begin
                    if (accept) begin
                        cmd_opcode <= s_axis_tdata;
                        checksum   <= checksum ^ s_axis_tdata;
                        state      <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        cmd_len  <= s_axis_tdata;
                        checksum <= checksum ^ s_axis_tdata;
                        if (s_axis_tdata > 8'(MAX_LEN)) begin
                            err_len <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= HUNT;
                        end else if (s_axis_tdata == 8'h00) begin
                            state <= CHK;
                        end else begin
                            state <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (accept) begin
                        checksum <= checksum ^ s_axis_tdata;
                        wr_idx   <= wr_idx + 1'b1;
                        if (8'(wr_idx) == cmd_len - 8'd1) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (s_axis_tdata == checksum) begin
                            state         <= HOLD;
                            cmd_valid     <= 1'b1;
                            s_axis_tready <= 1'b0;
                        end else begin
                            err_chk <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= HUNT;
                        end
                    end
                end
                HOLD: begin
                    s_axis_tready <= cmd_ready;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= HUNT;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
`ifdef CCU_CMD_TIMEOUT_EN
            if (timeout_hit) begin
                state       <= HUNT;
                err_timeout <= 1'b1;
                err_cnt     <= sat_inc(err_cnt);
            end
`else
            if (timeout_hit) begin
                state <= HUNT;
            end
`endif
        end
    end

    // Payload buffer; contents after reset are don't-care so it carries no reset.
    always_ff @(posedge axi_aclk) begin
        if (state == PAY && accept) begin
            buffer[wr_idx] <= s_axis_tdata;
        end
    end

    // Combinational payload read; addresses past the buffer return zero.
    always_comb begin
        cmd_rd_data = 8'h00;
        if (rd_addr_ext < 32'(MAX_LEN)) begin
            cmd_rd_data = buffer[cmd_rd_addr];
        end
    end

endmodule

// File: tb/tb_ccu_cmd_parser.sv
// Directed testbench for ccu_cmd_parser.
module tb_ccu_cmd_parser;

    localparam int AW = 4;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [7:0]    cmd_opcode;
    logic [7:0]    cmd_len;
    logic [AW-1:0] cmd_rd_addr = '0;
    logic [7:0]    cmd_rd_data;
    logic          err_chk;
    logic          err_len;
    logic [7:0]    err_cnt;
`ifdef CCU_CMD_TIMEOUT_EN
    logic          err_timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 axi_aclk = ~axi_aclk;

`ifdef CCU_CMD_TIMEOUT_EN
    ccu_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .AW(AW), .TIMEOUT_CYCLES(8)) dut (
`else
    ccu_cmd_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .AW(AW)) dut (
`endif
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_len       (cmd_len),
        .cmd_rd_addr   (cmd_rd_addr),
        .cmd_rd_data   (cmd_rd_data),
        .err_chk       (err_chk),
        .err_len       (err_len),
        .err_cnt       (err_cnt)
`ifdef CCU_CMD_TIMEOUT_EN
        ,
        .err_timeout   (err_timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    // Offer one byte and return #1 after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_tready_timeout", 32'(n), 32'd0);
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        cmd_rd_addr = a;
        #1;
        check(tag, 32'(cmd_rd_data), 32'(exp));
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(cmd_valid), 32'd0);
        check({tag, "_tready_back"}, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;

        // Reset state
        tick();
        tick();
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_opcode", 32'(cmd_opcode), 32'd0);
        check("rst_len", 32'(cmd_len), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err_pulses", {30'd0, err_chk, err_len}, 32'd0);
        axi_aresetn = 1'b1;
        tick();
        check("tready_after_rst", 32'(s_axis_tready), 32'd1);

        // Valid frame, CCU not ready
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send_frame(q);
        check("f1_valid", 32'(cmd_valid), 32'd1);
        check("f1_tready_hold", 32'(s_axis_tready), 32'd0);
        check("f1_opcode", 32'(cmd_opcode), 32'h10);
        check("f1_len", 32'(cmd_len), 32'h02);
        rd("f1_rd0", 4'd0, 8'h11);
        rd("f1_rd1", 4'd1, 8'h22);
        tick();
        check("f1_valid_held", 32'(cmd_valid), 32'd1);
        handshake("f1");

        // Leading garbage and zero length
        q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01};
        foreach (q[i]) begin
            send(q[i]);
            check("f2_no_err", {30'd0, err_chk, err_len}, 32'd0);
        end
        check("f2_valid", 32'(cmd_valid), 32'd1);
        check("f2_opcode", 32'(cmd_opcode), 32'h01);
        check("f2_len", 32'(cmd_len), 32'h00);
        check("f2_err_cnt", 32'(err_cnt), 32'd0);
        handshake("f2");

        // Bad checksum then a valid frame
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        send_frame(q);
        check("f3_err_chk", 32'(err_chk), 32'd1);
        check("f3_err_cnt", 32'(err_cnt), 32'd1);
        check("f3_valid", 32'(cmd_valid), 32'd0);
        tick();
        check("f3_err_chk_1cyc", 32'(err_chk), 32'd0);
        q = '{8'hA5, 8'h20, 8'h01, 8'h33, 8'h12};
        send_frame(q);
        check("f4_valid", 32'(cmd_valid), 32'd1);
        check("f4_opcode", 32'(cmd_opcode), 32'h20);
        check("f4_len", 32'(cmd_len), 32'h01);
        rd("f4_rd0", 4'd0, 8'h33);
        handshake("f4");

        // Length overflow, then 17 bytes without a sync byte
        q = '{8'hA5, 8'h03, 8'h11};
        send_frame(q);
        check("f5_err_len", 32'(err_len), 32'd1);
        check("f5_err_cnt", 32'(err_cnt), 32'd2);
        check("f5_tready", 32'(s_axis_tready), 32'd1);
        for (int i = 1; i <= 17; i++) begin
            send(8'(i));
            check("f5_quiet", {29'd0, cmd_valid, err_chk, err_len}, 32'd0);
        end
        check("f5_err_cnt_after", 32'(err_cnt), 32'd2);

        // Maximum length frame: payload 0..15 XORs to 0, so CHK = 40 ^ 10 = 50
        q = '{8'hA5, 8'h40, 8'h10};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'h50);
        send_frame(q);
        check("f6_valid", 32'(cmd_valid), 32'd1);
        check("f6_len", 32'(cmd_len), 32'h10);
        rd("f6_rd15", 4'd15, 8'h0F);
        rd("f6_rd7", 4'd7, 8'h07);
        handshake("f6");

        // Backpressure: second frame offered while the first is held
        q = '{8'hA5, 8'h11, 8'h01, 8'h44, 8'h54};
        send_frame(q);
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("bp_tready", 32'(s_axis_tready), 32'd0);
        check("bp_valid", 32'(cmd_valid), 32'd1);
        check("bp_opcode", 32'(cmd_opcode), 32'h11);
        rd("bp_rd0", 4'd0, 8'h44);
        handshake("bp");
        q = '{8'hA5, 8'h22, 8'h02, 8'h55, 8'h66, 8'h13};
        send_frame(q);
        check("bp2_valid", 32'(cmd_valid), 32'd1);
        check("bp2_opcode", 32'(cmd_opcode), 32'h22);
        check("bp2_len", 32'(cmd_len), 32'h02);
        rd("bp2_rd0", 4'd0, 8'h55);
        rd("bp2_rd1", 4'd1, 8'h66);
        handshake("bp2");

        // Reset mid-frame
        q = '{8'hA5, 8'h10};
        send_frame(q);
        axi_aresetn = 1'b0;
        tick();
        check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_opcode", 32'(cmd_opcode), 32'd0);
        axi_aresetn = 1'b1;
        tick();
        q = '{8'hA5, 8'h30, 8'h00, 8'h30};
        send_frame(q);
        check("post_rst_valid", 32'(cmd_valid), 32'd1);
        check("post_rst_opcode", 32'(cmd_opcode), 32'h30);
        check("post_rst_len", 32'(cmd_len), 32'h00);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        handshake("post_rst");

`ifdef CCU_CMD_TIMEOUT_EN
        // Inter-byte timeout after A5 10 with 8 idle cycles
        q = '{8'hA5, 8'h10};
        send_frame(q);
        n = 0;
        while (!err_timeout && n < 20) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd8);
        check("to_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        check("to_pulse_1cyc", 32'(err_timeout), 32'd0);
        q = '{8'hA5, 8'h31, 8'h00, 8'h31};
        send_frame(q);
        check("to_next_valid", 32'(cmd_valid), 32'd1);
        check("to_next_opcode", 32'(cmd_opcode), 32'h31);
        handshake("to_next");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccu_cmd_parser.md
Name: ccu_cmd_parser

Overview:
- Downstream consumer of the SPI receive stage's 8-bit AXI-Stream. Sits between the SPI receive stage and the CCU.
- Hunts for a sync byte, then parses frames of the form SYNC, CMD, LEN, PAYLOAD[LEN], CHK, where CHK is the XOR of CMD, LEN and all payload bytes.
- Buffers the payload internally and presents each validated command to the CCU with a valid/ready handshake plus a random-access payload read port.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; also sets the buffer depth.
- AW, $clog2(MAX_LEN), payload read address width.
- TIMEOUT_CYCLES, 1024, inter-byte timeout in axi_aclk cycles; used only with the optional feature.

Ports:
- axi_aclk  in  1  the single clock.
- axi_aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8  byte from the SPI receive stage.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  parser can accept a byte.
- s_axis_tlast  in  1  upstream burst end; ignored for framing.
- cmd_valid  out  1  validated command available.
- cmd_ready  in  1  CCU accepts the command.
- cmd_opcode  out  8  CMD byte of the held frame.
- cmd_len  out  8  payload length of the held frame.
- cmd_rd_addr  in  AW  payload byte index.
- cmd_rd_data  out  8  payload byte at cmd_rd_addr; combinational read.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_len  out  1  one-cycle pulse when LEN > MAX_LEN.
- err_cnt  out  8  saturating count of all errors.

Behaviour:
- Clocking and reset: one clock, axi_aclk. Reset is synchronous and active-low on axi_aresetn.
- Reset values: state HUNT, s_axis_tready=0, cmd_valid=0, cmd_opcode=0, cmd_len=0, err_chk=0, err_len=0, err_cnt=0, checksum=0, write index=0.
- First cycle after reset release: s_axis_tready=1.
- Byte acceptance: a byte is accepted only on a cycle with s_axis_tvalid && s_axis_tready.
- s_axis_tready is registered. It is 1 in HUNT/CMD/LEN/PAY/CHK and 0 in HOLD.
- State HUNT:
  - accepted byte == SYNC_BYTE -> CMD, clear checksum to 0, clear write index to 0.
  - any other byte is dropped silently; no error is raised.
- State CMD: latch the byte into cmd_opcode, XOR it into checksum -> LEN.
- State LEN:
  - LEN > MAX_LEN -> pulse err_len, increment err_cnt, go to HUNT.
  - LEN == 0 -> CHK.
  - otherwise -> PAY.
  - In all cases the byte is latched into cmd_len and XORed into checksum.
- State PAY:
  - write the byte to buffer[index], XOR it into checksum, increment index.
  - when index reaches cmd_len-1 on an accept -> CHK.
- State CHK:
  - byte == checksum -> HOLD.
  - mismatch -> pulse err_chk, increment err_cnt, go to HUNT.
- State HOLD:
  - cmd_valid=1.
  - cmd_opcode, cmd_len and buffer contents are stable.
  - cmd_ready=1 -> HUNT; cmd_valid drops next cycle and s_axis_tready returns to 1 next cycle.
- Latency: cmd_valid rises on the first clock edge after the CHK byte is accepted. If cmd_ready is already high, the handshake completes on the next edge, so cmd_valid stays high for exactly 1 cycle.
- cmd_ready while cmd_valid=0: ignored.
- Error pulses: each is exactly one cycle, registered. They coincide with the cycle after the offending byte is accepted.
- err_cnt: saturates at 8'hFF and does not wrap.
- Backpressure: while in HOLD, upstream stalls. No bytes are lost, because upstream holds tvalid/tdata.
- Reset asserted mid-frame: the partial frame is discarded and outputs go to their reset values on that edge. The buffer contents are don't-care.
- cmd_rd_addr >= cmd_len: cmd_rd_data returns stale buffer data, which is don't-care. Out-of-range addresses (>= MAX_LEN) return 8'h00.
- s_axis_tlast: has no effect on framing. Upstream tlast marks FIFO-drain boundaries, not frame ends.

Optional Feature:
- Macro: CCU_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments every cycle while the state is CMD/LEN/PAY/CHK without an accept.
  - Reaching TIMEOUT_CYCLES -> go to HUNT, increment err_cnt, and pulse the extra output port err_timeout (out, 1) for one cycle.
  - The counter is idle in HUNT and HOLD.
- Not defined: no counter and no err_timeout port; a stalled partial frame waits indefinitely.

Test Plan:
- Valid frame: send A5 10 02 11 22 21 with tvalid continuous and cmd_ready=0 -> cmd_valid=1 one cycle after the 21 byte, cmd_opcode=10, cmd_len=02, rd_addr 0/1 returns 11/22, s_axis_tready=0. Raise cmd_ready -> cmd_valid=0 and tready=1 next cycle.
- Leading garbage and zero length: send 00 FF 5A A5 01 00 01 -> no error pulses, cmd_valid with opcode 01, len 00, err_cnt stays 0.
- Bad checksum: send A5 10 02 11 22 20 -> err_chk pulse for 1 cycle, err_cnt=1, cmd_valid stays 0. A following valid frame is parsed correctly.
- Length overflow (MAX_LEN=16): send A5 03 11 -> err_len pulse, state HUNT. The next 17 bytes, which contain no A5, produce nothing.
- Backpressure: a second full frame is offered while the first is held, with tvalid asserted throughout -> no byte is consumed until cmd_ready. The second frame then decodes correctly.
- Reset and timeout: pulse axi_aresetn low after A5 10 -> next frame decodes cleanly. With CCU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8, send A5 10 then idle 8 cycles -> err_timeout pulse, err_cnt increments by 1.
